instr_encoder_loader: RTL and testbench
=======================================

Name: instr_encoder_loader

Overview:
Programming-side counterpart of the control decoder. It accepts instruction field tuples (opcode, register types and indices, immediate) over a valid/ready stream and checks each opcode against the decoder's legal set. Legal tuples are packed into 32-bit instruction words and written sequentially into instruction memory. It sits between the host/boot loader port and the instruction memory write port, and runs before the core is released from its program-load phase.

Parameters:
ADDR_W, 8, instruction memory address width; capacity = 2^ADDR_W words.
BASE_ADDR, 0, first write address after start.

Ports:
clk  in  1  system clock
rst  in  1  reset; synchronous, active-high
start  in  1  one-cycle pulse; begins a load session
in_valid  in  1  field tuple valid
in_ready  out  1  loader can accept a tuple this cycle
in_last  in  1  marks the final tuple of the program
in_opcode  in  5  opcode
in_rd_type  in  1  rd type (1 = vector register)
in_rd  in  4  rd index
in_rs1_type  in  1  rs1 type
in_rs1  in  4  rs1 index
in_rs2_type  in  1  rs2 type
in_rs2  in  4  rs2 index
in_imm  in  12  immediate
imem_we  out  1  instruction memory write enable
imem_addr  out  ADDR_W  write address
imem_wdata  out  32  packed instruction word
busy  out  1  session active
done  out  1  session complete (level)
err_illegal  out  1  sticky: an illegal opcode was dropped
err_overflow  out  1  sticky: memory filled before in_last
word_count  out  ADDR_W+1  words written this session

Behaviour:
- Reset values:
  - All outputs are 0, except imem_addr = BASE_ADDR.
  - State is IDLE.
  - Reset takes effect on any cycle, including mid-session. A pending write is discarded, with no imem_we on the following cycle.
- Word format:
  - [31:27] opcode; [26] rd_type; [25:22] rd; [21] rs1_type; [20:17] rs1; [16] rs2_type; [15:12] rs2; [11:0] imm.
- Legal opcodes: 11000, 10101, 11011, 01100, 10001, 11100, 10110, 10111, 11010, 10100, 11001, 11110, 11111, 10011, 10010, 11101. All other opcodes are illegal.
- States: IDLE, LOAD, DONE.
  - IDLE: in_ready = 0. start -> LOAD. On entry to LOAD:
    - wr_ptr = BASE_ADDR and word_count = 0;
    - err_illegal, err_overflow and done are cleared;
    - busy = 1.
  - LOAD: in_ready = 1, unless the final write is pending.
    - Accept = in_valid & in_ready.
  - DONE: done = 1, busy = 0, in_ready = 0. start -> LOAD, with the same clears as above.
- start in LOAD is ignored.
- Accept of a legal tuple (pipeline, latency 1):
  - The packed word is registered.
  - On the next cycle: imem_we = 1 for exactly one cycle, imem_addr = wr_ptr, imem_wdata = packed word.
  - wr_ptr and word_count increment in the same cycle as imem_we.
  - Back-to-back accepts give back-to-back writes at consecutive addresses.
- Accept of an illegal tuple:
  - No write is produced; err_illegal is set.
  - wr_ptr and word_count are unchanged.
  - If in_last is set on that tuple, the session still ends.
- in_last accepted:
  - in_ready drops the next cycle.
  - After the final write cycle (or immediately for an illegal last tuple), the state moves to DONE.
- Overflow:
  - When the write to address 2^ADDR_W-1 occurs without in_last, err_overflow is set and the state moves to DONE.
  - in_ready is 0 from the cycle after the accept that maps to address 2^ADDR_W-1.
  - wr_ptr never wraps.
- Simultaneous events:
  - in_valid in IDLE/DONE is ignored.
  - start together with in_valid in IDLE: the tuple is not accepted that cycle.
  - rst overrides start.

Test Plan:
- rst, start, tuple {10101, rd=3, rs1=1, rs2=2, types 0, imm 0, last=1} -> next cycle imem_we=1, addr=0, wdata=0xA8C22000; then done=1, word_count=1, busy=0.
- start, then three back-to-back tuples (mov-imm 11000 rd=5 imm=0x0FF first, last on the third) -> writes at addr 0,1,2 on consecutive cycles; word 0 = 0xC14000FF; word_count=3.
- start, then tuple opcode 00000 followed by a legal tuple with last -> no write for the first tuple; err_illegal=1; the legal word is written at addr 0; word_count=1.
- ADDR_W=2, start, 5 tuples with no in_last -> writes at addr 0..3; err_overflow=1; in_ready=0 after the 4th accept; 5th tuple not accepted; state DONE.
- rst asserted the cycle after an accept -> no imem_we on the following cycle; all outputs at reset values.
- After done, start again -> done, err flags and word_count cleared; writes resume at BASE_ADDR.

Source files
------------

// File: rtl/instr_encoder_loader.sv
// instr_encoder_loader: accepts instruction field tuples over a valid/ready
// stream, drops tuples whose opcode the control decoder would reject, packs
// legal tuples into 32-bit words and writes them sequentially into
// instruction memory during the program-load phase.
module instr_encoder_loader #(
    parameter int ADDR_W    = 8,
    parameter int BASE_ADDR = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_last,
    input  logic [4:0]        in_opcode,
    input  logic              in_rd_type,
    input  logic [3:0]        in_rd,
    input  logic              in_rs1_type,
    input  logic [3:0]        in_rs1,
    input  logic              in_rs2_type,
    input  logic [3:0]        in_rs2,
    input  logic [11:0]       in_imm,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              busy,
    output logic              done,
    output logic              err_illegal,
    output logic              err_overflow,
    output logic [ADDR_W:0]   word_count
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [ADDR_W-1:0] BASE_A = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W-1:0] LAST_A = {ADDR_W{1'b1}};

    // Opcodes the control decoder recognises; everything else is dropped.
    function automatic logic is_legal(input logic [4:0] op);
        logic ok;
        case (op)
            5'b11000, 5'b10101, 5'b11011, 5'b01100,
            5'b10001, 5'b11100, 5'b10110, 5'b10111,
            5'b11010, 5'b10100, 5'b11001, 5'b11110,
            5'b11111, 5'b10011, 5'b10010, 5'b11101: ok = 1'b1;
            default:                                ok = 1'b0;
        endcase
        return ok;
    endfunction

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [ADDR_W:0]     count_q, count_d;
    logic                stop_q, stop_d;       // no further tuples this session
    logic                we_q, we_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [31:0]         wdata_q, wdata_d;
    logic                ready_q, ready_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                err_ill_q, err_ill_d;
    logic                err_ovf_q, err_ovf_d;

    logic                accept_s;
    logic                legal_s;
    logic [31:0]         packed_s;

    assign accept_s = in_valid & ready_q;
    assign legal_s  = is_legal(in_opcode);
    assign packed_s = {in_opcode, in_rd_type, in_rd, in_rs1_type, in_rs1,
                       in_rs2_type, in_rs2, in_imm};

    // Next-state, write-port and status logic for the load session.
    always_comb begin
        state_d   = state_q;
        wr_ptr_d  = wr_ptr_q;
        count_d   = count_q;
        stop_d    = stop_q;
        we_d      = 1'b0;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        err_ill_d = err_ill_q;
        err_ovf_d = err_ovf_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d   = ST_LOAD;
                    wr_ptr_d  = BASE_A;
                    count_d   = '0;
                    stop_d    = 1'b0;
                    err_ill_d = 1'b0;
                    err_ovf_d = 1'b0;
                end else begin
                    state_d = state_q;
                end
            end
            ST_LOAD: begin
                if (stop_q) begin
                    // Final write has been presented this cycle.
                    state_d = ST_DONE;
                end else if (accept_s) begin
                    if (legal_s) begin
                        we_d    = 1'b1;
                        addr_d  = wr_ptr_q;
                        wdata_d = packed_s;
                        count_d = count_q + (ADDR_W+1)'(1'b1);
                        if (wr_ptr_q != LAST_A) begin
                            wr_ptr_d = wr_ptr_q + ADDR_W'(1'b1);
                        end else begin
                            wr_ptr_d = wr_ptr_q;   // saturate, never wrap
                        end
                        if (in_last) begin
                            stop_d = 1'b1;
                        end else if (wr_ptr_q == LAST_A) begin
                            stop_d    = 1'b1;
                            err_ovf_d = 1'b1;
                        end else begin
                            stop_d = 1'b0;
                        end
                    end else begin
                        err_ill_d = 1'b1;
                        if (in_last) begin
                            state_d = ST_DONE;
                        end else begin
                            state_d = ST_LOAD;
                        end
                    end
                end else begin
                    state_d = ST_LOAD;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        ready_d = (state_d == ST_LOAD) && !stop_d;
        busy_d  = (state_d == ST_LOAD);
        done_d  = (state_d == ST_DONE);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            wr_ptr_q  <= BASE_A;
            count_q   <= '0;
            stop_q    <= 1'b0;
            we_q      <= 1'b0;
            addr_q    <= BASE_A;
            wdata_q   <= 32'h0000_0000;
            ready_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_ill_q <= 1'b0;
            err_ovf_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            wr_ptr_q  <= wr_ptr_d;
            count_q   <= count_d;
            stop_q    <= stop_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            ready_q   <= ready_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            err_ill_q <= err_ill_d;
            err_ovf_q <= err_ovf_d;
        end
    end

    assign in_ready     = ready_q;
    assign imem_we      = we_q;
    assign imem_addr    = addr_q;
    assign imem_wdata   = wdata_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign err_illegal  = err_ill_q;
    assign err_overflow = err_ovf_q;
    assign word_count   = count_q;

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Directed bench for instr_encoder_loader: a table of single-tuple sessions
// plus hand-written multi-cycle sequences; a second instance with ADDR_W=2
// exercises memory overflow.
module tb_instr_encoder_loader;

    logic        clk = 1'b0;
    logic        rst, start, start2, in_valid, in_last;
    logic [4:0]  in_opcode;
    logic        in_rd_type, in_rs1_type, in_rs2_type;
    logic [3:0]  in_rd, in_rs1, in_rs2;
    logic [11:0] in_imm;

    logic        in_ready, imem_we, busy, done, err_illegal, err_overflow;
    logic [7:0]  imem_addr;
    logic [31:0] imem_wdata;
    logic [8:0]  word_count;

    logic        in_ready2, imem_we2, busy2, done2, err_illegal2, err_overflow2;
    logic [1:0]  imem_addr2;
    logic [31:0] imem_wdata2;
    logic [2:0]  word_count2;

    int n_cmp = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    instr_encoder_loader #(.ADDR_W(8), .BASE_ADDR(0)) dut (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid),
        .in_ready(in_ready), .in_last(in_last), .in_opcode(in_opcode),
        .in_rd_type(in_rd_type), .in_rd(in_rd), .in_rs1_type(in_rs1_type),
        .in_rs1(in_rs1), .in_rs2_type(in_rs2_type), .in_rs2(in_rs2),
        .in_imm(in_imm), .imem_we(imem_we), .imem_addr(imem_addr),
        .imem_wdata(imem_wdata), .busy(busy), .done(done),
        .err_illegal(err_illegal), .err_overflow(err_overflow),
        .word_count(word_count)
    );

    instr_encoder_loader #(.ADDR_W(2), .BASE_ADDR(0)) dut2 (
        .clk(clk), .rst(rst), .start(start2), .in_valid(in_valid),
        .in_ready(in_ready2), .in_last(in_last), .in_opcode(in_opcode),
        .in_rd_type(in_rd_type), .in_rd(in_rd), .in_rs1_type(in_rs1_type),
        .in_rs1(in_rs1), .in_rs2_type(in_rs2_type), .in_rs2(in_rs2),
        .in_imm(in_imm), .imem_we(imem_we2), .imem_addr(imem_addr2),
        .imem_wdata(imem_wdata2), .busy(busy2), .done(done2),
        .err_illegal(err_illegal2), .err_overflow(err_overflow2),
        .word_count(word_count2)
    );

    typedef struct {
        logic [4:0]  op;
        logic        rdt;
        logic [3:0]  rd;
        logic        r1t;
        logic [3:0]  r1;
        logic        r2t;
        logic [3:0]  r2;
        logic [11:0] imm;
        logic        legal;
        logic [31:0] word;
    } vec_t;

    vec_t vecs[9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input vec_t v, input logic last);
        in_valid    = 1'b1;
        in_last     = last;
        in_opcode   = v.op;
        in_rd_type  = v.rdt;
        in_rd       = v.rd;
        in_rs1_type = v.r1t;
        in_rs1      = v.r1;
        in_rs2_type = v.r2t;
        in_rs2      = v.r2;
        in_imm      = v.imm;
    endtask

    task automatic start_pulse();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    initial begin
        //          op        rdt  rd    r1t  r1    r2t  r2    imm      legal word
        vecs[0] = '{5'b10101, 1'b0, 4'h3, 1'b0, 4'h1, 1'b0, 4'h2, 12'h000, 1'b1, 32'hA8C2_2000};
        vecs[1] = '{5'b11000, 1'b0, 4'h5, 1'b0, 4'h0, 1'b0, 4'h0, 12'h0FF, 1'b1, 32'hC140_00FF};
        vecs[2] = '{5'b11111, 1'b1, 4'hF, 1'b1, 4'hF, 1'b1, 4'hF, 12'hFFF, 1'b1, 32'hFFFF_FFFF};
        vecs[3] = '{5'b01100, 1'b0, 4'h0, 1'b0, 4'h0, 1'b0, 4'h0, 12'h123, 1'b1, 32'h6000_0123};
        vecs[4] = '{5'b10010, 1'b1, 4'hA, 1'b0, 4'h5, 1'b1, 4'h3, 12'hABC, 1'b1, 32'h968B_3ABC};
        vecs[5] = '{5'b00000, 1'b0, 4'h1, 1'b0, 4'h1, 1'b0, 4'h1, 12'h001, 1'b0, 32'h0000_0000};
        vecs[6] = '{5'b01111, 1'b0, 4'h2, 1'b0, 4'h2, 1'b0, 4'h2, 12'h002, 1'b0, 32'h0000_0000};
        vecs[7] = '{5'b10000, 1'b1, 4'h7, 1'b1, 4'h7, 1'b1, 4'h7, 12'h777, 1'b0, 32'h0000_0000};
        vecs[8] = '{5'b11101, 1'b0, 4'h0, 1'b0, 4'h0, 1'b0, 4'h0, 12'h000, 1'b1, 32'hE800_0000};

        rst = 1'b1; start = 1'b0; start2 = 1'b0; in_valid = 1'b0; in_last = 1'b0;
        in_opcode = 5'd0; in_rd_type = 1'b0; in_rd = 4'd0; in_rs1_type = 1'b0;
        in_rs1 = 4'd0; in_rs2_type = 1'b0; in_rs2 = 4'd0; in_imm = 12'd0;
        tick();
        tick();
        rst = 1'b0;

        // Reset values
        chk("rst_we",    {31'd0, imem_we}, 32'd0);
        chk("rst_addr",  {24'd0, imem_addr}, 32'd0);
        chk("rst_wdata", imem_wdata, 32'd0);
        chk("rst_flags", {26'd0, in_ready, busy, done, err_illegal, err_overflow, imem_we2}, 32'd0);
        chk("rst_count", {23'd0, word_count}, 32'd0);

        // Table of single-tuple sessions, each tuple carries in_last
        for (int i = 0; i < 9; i++) begin
            start_pulse();
            chk("tbl_busy", {30'd0, busy, in_ready}, 32'd3);
            drive(vecs[i], 1'b1);
            tick();
            in_valid = 1'b0;
            chk("tbl_we", {31'd0, imem_we}, {31'd0, vecs[i].legal});
            if (vecs[i].legal) begin
                chk("tbl_wdata", imem_wdata, vecs[i].word);
                chk("tbl_addr", {24'd0, imem_addr}, 32'd0);
            end
            chk("tbl_ready_drop", {31'd0, in_ready}, 32'd0);
            tick();
            chk("tbl_done", {29'd0, done, busy, imem_we}, 32'd4);
            chk("tbl_count", {23'd0, word_count}, {31'd0, vecs[i].legal});
            chk("tbl_err_ill", {31'd0, err_illegal}, {31'd0, ~vecs[i].legal});
        end

        // Three back-to-back tuples; start during LOAD is ignored
        start_pulse();
        drive(vecs[1], 1'b0);
        tick();
        chk("b2b_w0", {imem_we, 23'd0, imem_addr}, 32'h8000_0000);
        chk("b2b_d0", imem_wdata, 32'hC140_00FF);
        drive(vecs[0], 1'b0);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("b2b_w1", {imem_we, 23'd0, imem_addr}, 32'h8000_0001);
        chk("b2b_d1", imem_wdata, 32'hA8C2_2000);
        drive(vecs[3], 1'b1);
        tick();
        in_valid = 1'b0;
        chk("b2b_w2", {imem_we, 23'd0, imem_addr}, 32'h8000_0002);
        chk("b2b_d2", imem_wdata, 32'h6000_0123);
        tick();
        chk("b2b_done", {28'd0, done, busy, imem_we, err_illegal}, 32'd8);
        chk("b2b_count", {23'd0, word_count}, 32'd3);

        // Illegal tuple followed by a legal last tuple; restart clears flags
        start_pulse();
        chk("restart_clr", {28'd0, done, err_illegal, err_overflow, busy}, 32'd1);
        chk("restart_cnt", {23'd0, word_count}, 32'd0);
        drive(vecs[5], 1'b0);
        tick();
        chk("ill_nowrite", {30'd0, imem_we, err_illegal}, 32'd1);
        chk("ill_count", {23'd0, word_count}, 32'd0);
        drive(vecs[0], 1'b1);
        tick();
        in_valid = 1'b0;
        chk("ill_then_w", {imem_we, 23'd0, imem_addr}, 32'h8000_0000);
        chk("ill_then_d", imem_wdata, 32'hA8C2_2000);
        tick();
        chk("ill_done", {30'd0, done, err_illegal}, 32'd3);
        chk("ill_count1", {23'd0, word_count}, 32'd1);

        // Overflow on the ADDR_W=2 instance
        start2 = 1'b1;
        tick();
        start2 = 1'b0;
        drive(vecs[1], 1'b0);
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("ovf_write", {imem_we2, 29'd0, imem_addr2}, {1'b1, 29'd0, 2'(k)});
        end
        chk("ovf_ready0", {30'd0, in_ready2, err_overflow2}, 32'd1);
        tick();
        chk("ovf_done", {29'd0, done2, busy2, imem_we2}, 32'd4);
        chk("ovf_count", {29'd0, word_count2}, 32'd4);
        tick();
        in_valid = 1'b0;
        chk("ovf_5th", {29'd0, imem_we2, in_ready2, err_overflow2}, 32'd1);
        chk("ovf_wdata", imem_wdata2, 32'hC140_00FF);

        // Reset the cycle after an accept discards the pending write
        start_pulse();
        drive(vecs[2], 1'b0);
        tick();
        chk("mid_we", {31'd0, imem_we}, 32'd1);
        rst = 1'b1;
        in_valid = 1'b0;
        tick();
        chk("mid_rst_we", {31'd0, imem_we}, 32'd0);
        chk("mid_rst_out", {imem_wdata[7:0], imem_addr, 1'b0, word_count, in_ready, busy, done, err_illegal, err_overflow, 1'b0}, 32'd0);
        chk("mid_rst_d2", {29'd0, done2, err_overflow2, busy2}, 32'd0);
        // rst overrides start
        start = 1'b1;
        tick();
        chk("rst_over_start", {31'd0, busy}, 32'd0);
        rst = 1'b0;
        // start together with in_valid in IDLE: tuple not taken that cycle
        drive(vecs[4], 1'b1);
        tick();
        start = 1'b0;
        chk("start_valid_nowr", {30'd0, imem_we, busy}, 32'd1);
        tick();
        in_valid = 1'b0;
        chk("after_start_w", {imem_we, 23'd0, imem_addr}, 32'h8000_0000);
        chk("after_start_d", imem_wdata, 32'h968B_3ABC);
        tick();
        chk("after_start_done", {22'd0, done, word_count}, {22'd0, 1'b1, 9'd1});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
